add_sched: RTL and testbench

Multi-requester scheduler for the shared 32-bit ripple-carry adder (`fa32`). It arbitrates round-robin among `NREQ` requesters and latches the winner's operands into an internal `fa32` instance. It then holds those operands stable for a fixed number of settle cycles to cover the ripple delay, and presents a registered result on a single valid/ready response port. It sits between the ALU issue logic and the one adder instance the design can afford.

---
 rtl/add_sched.sv | 384 ++++++++++++++++++++++++++++++++++++++
 tb/tb_add_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/add_sched.sv
// -----------------------------------------------------------------------------
// add_sched -- round-robin scheduler in front of one shared 32-bit
// ripple-carry adder (fa32).
//
// The scheduler grants one of NREQ requesters and latches that requester's
// operands. It holds them at fa32 for SETTLE_CYCLES cycles so the ripple
// carry has time to settle, and then captures sum, carry out and signed
// overflow into result registers. The result is offered on a single
// valid/ready port. The next grant is only made after the result has been
// taken.
//
// Build option:
//   ADD_SCHED_SUB_EN  defined   : req_sub selects A-B (B inverted, carry-in 1)
//                     undefined : req_sub is ignored and every op is A+B
//
// Parameters:
//   NREQ           number of requesters (2..8)
//   SETTLE_CYCLES  cycles operands are held at fa32 before capture (>= 1)
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous, active-high reset
//   req_valid  in   [NREQ]       per-requester request
//   req_a      in   [NREQ*32]    operand A, requester i at [32i+31:32i]
//   req_b      in   [NREQ*32]    operand B, same packing
//   req_sub    in   [NREQ]       1 = A-B, 0 = A+B
//   req_ready  out  [NREQ]       one-hot accept pulse (combinational)
//   rsp_valid  out               result available
//   rsp_ready  in                consumer takes the result
//   rsp_id     out  [clog2 NREQ] owner of the result
//   rsp_sum    out  [32]         sum / difference
//   rsp_cout   out               carry out (for subtract: 1 = no borrow)
//   rsp_ovf    out               signed overflow
// -----------------------------------------------------------------------------

// 32-bit ripple-carry adder, built bit by bit from a full-adder helper.
module fa32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  // One full-adder cell: returns {carry_out, sum_bit}.
  function automatic logic [1:0] fa_bit(input logic x, input logic y, input logic ci);
    logic s;
    logic co;
    s  = x ^ y ^ ci;
    co = (x & y) | (ci & (x ^ y));
    return {co, s};
  endfunction

  logic       carry_s;
  logic [1:0] cell_s;

  // Ripple the carry from bit 0 to bit 31.
  always_comb begin
    carry_s = cin;
    sum     = 32'h0000_0000;
    cell_s  = 2'b00;
    for (int i = 0; i < 32; i++) begin
      cell_s  = fa_bit(a[i], b[i], carry_s);
      sum[i]  = cell_s[0];
      carry_s = cell_s[1];
    end
    cout = carry_s;
  end

endmodule

module add_sched #(
  parameter int NREQ          = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*32-1:0]      req_a,
  input  logic [NREQ*32-1:0]      req_b,
  input  logic [NREQ-1:0]         req_sub,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [31:0]             rsp_sum,
  output logic                    rsp_cout,
  output logic                    rsp_ovf
);

  localparam int IDW = $clog2(NREQ);
  // Counter only needs to hold SETTLE_CYCLES-1.
  localparam int CW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state_r;
  state_t next_state_s;

  // Round-robin pointer and settle counter.
  logic [IDW-1:0] rr_ptr_r;
  logic [CW-1:0]  cnt_r;

  // Grant search results.
  logic           grant_any_s;
  logic [IDW-1:0] grant_idx_s;
  logic [IDW-1:0] rr_next_s;

  // FSM strobes.
  logic accept_s;
  logic capture_s;
  logic release_s;

  // Unpacked views of the operand buses.
  logic [31:0] a_arr_s [NREQ];
  logic [31:0] b_arr_s [NREQ];

  // Operand latch feeding fa32.
  logic [31:0]    a_r;
  logic [31:0]    b_r;
  logic [IDW-1:0] id_r;

  // Adder path.
  logic [31:0] b_eff_s;
  logic        cin_s;
  logic [31:0] sum_s;
  logic        cout_s;
  logic        ovf_s;

  // Result registers.
  logic           rsp_valid_r;
  logic [IDW-1:0] rsp_id_r;
  logic [31:0]    rsp_sum_r;
  logic           rsp_cout_r;
  logic           rsp_ovf_r;

  // ---------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------

  // Slice the packed operand buses into one word per requester.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr_s[i] = req_a[i*32 +: 32];
      b_arr_s[i] = req_b[i*32 +: 32];
    end
  end

  // Find the first valid requester at or after rr_ptr, with wrap-around.
  // The loop scans offsets from high to low, so the smallest offset is
  // written last and therefore wins.
  always_comb begin
    logic [IDW:0] pos;
    grant_any_s = 1'b0;
    grant_idx_s = {IDW{1'b0}};
    pos         = {(IDW+1){1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = {1'b0, rr_ptr_r} + (IDW+1)'(k);
      if (pos >= (IDW+1)'(NREQ)) begin
        pos = pos - (IDW+1)'(NREQ);
      end else begin
        pos = pos;
      end
      if (req_valid[pos[IDW-1:0]]) begin
        grant_any_s = 1'b1;
        grant_idx_s = pos[IDW-1:0];
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // Pointer value after a grant: the requester just above the winner.
  always_comb begin
    if (grant_idx_s == IDW'(NREQ - 1)) begin
      rr_next_s = {IDW{1'b0}};
    end else begin
      rr_next_s = grant_idx_s + IDW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = SETTLE;
        end else begin
          next_state_s = IDLE;
        end
      end
      SETTLE: begin
        if (cnt_r == {CW{1'b0}}) begin
          next_state_s = DONE;
        end else begin
          next_state_s = SETTLE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Output strobes. Accept is held off while reset is asserted, so that
  // req_ready reads 0 during reset.
  always_comb begin
    accept_s  = 1'b0;
    capture_s = 1'b0;
    release_s = 1'b0;
    case (state_r)
      IDLE:    accept_s  = grant_any_s & ~rst;
      SETTLE:  capture_s = (cnt_r == {CW{1'b0}});
      DONE:    release_s = rsp_ready;
      default: begin
        accept_s  = 1'b0;
        capture_s = 1'b0;
        release_s = 1'b0;
      end
    endcase
  end

  // One-hot accept pulse to the granted requester.
  always_comb begin
    req_ready = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept_s & (grant_idx_s == IDW'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Operand latch, pointer and settle counter
  // ---------------------------------------------------------------------------

  // Capture the winner's operands and id at accept. They stay unchanged
  // until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r  <= 32'h0000_0000;
      b_r  <= 32'h0000_0000;
      id_r <= {IDW{1'b0}};
    end else if (accept_s) begin
      a_r  <= a_arr_s[grant_idx_s];
      b_r  <= b_arr_s[grant_idx_s];
      id_r <= grant_idx_s;
    end else begin
      a_r  <= a_r;
      b_r  <= b_r;
      id_r <= id_r;
    end
  end

  // Advance the round-robin pointer past each winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r <= {IDW{1'b0}};
    end else if (accept_s) begin
      rr_ptr_r <= rr_next_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Settle counter: loaded at accept, counts down while in SETTLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (accept_s) begin
      cnt_r <= CW'(SETTLE_CYCLES - 1);
    end else if ((state_r == SETTLE) && (cnt_r != {CW{1'b0}})) begin
      cnt_r <= cnt_r - CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Adder path
  // ---------------------------------------------------------------------------

`ifdef ADD_SCHED_SUB_EN
  logic sub_r;

  // Latch the subtract select along with the operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_r <= 1'b0;
    end else if (accept_s) begin
      sub_r <= req_sub[grant_idx_s];
    end else begin
      sub_r <= sub_r;
    end
  end

  // Subtract is A + ~B + 1.
  assign b_eff_s = sub_r ? ~b_r : b_r;
  assign cin_s   = sub_r;
`else
  // Subtract is not built, so req_sub has no load.
  logic unused_sub_s;
  assign unused_sub_s = ^req_sub;

  assign b_eff_s = b_r;
  assign cin_s   = 1'b0;
`endif

  fa32 u_fa32 (
    .a    (a_r),
    .b    (b_eff_s),
    .cin  (cin_s),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // Signed overflow: the operand signs agree and the result sign differs.
  assign ovf_s = (a_r[31] == b_eff_s[31]) & (sum_s[31] != a_r[31]);

  // ---------------------------------------------------------------------------
  // Result registers
  // ---------------------------------------------------------------------------

  // Capture the settled adder output. It is held until the next capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_sum_r  <= 32'h0000_0000;
      rsp_cout_r <= 1'b0;
      rsp_ovf_r  <= 1'b0;
      rsp_id_r   <= {IDW{1'b0}};
    end else if (capture_s) begin
      rsp_sum_r  <= sum_s;
      rsp_cout_r <= cout_s;
      rsp_ovf_r  <= ovf_s;
      rsp_id_r   <= id_r;
    end else begin
      rsp_sum_r  <= rsp_sum_r;
      rsp_cout_r <= rsp_cout_r;
      rsp_ovf_r  <= rsp_ovf_r;
      rsp_id_r   <= rsp_id_r;
    end
  end

  // Response valid: set with the capture, cleared when the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
    end else if (capture_s) begin
      rsp_valid_r <= 1'b1;
    end else if (release_s) begin
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_r;
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_sum   = rsp_sum_r;
  assign rsp_cout  = rsp_cout_r;
  assign rsp_ovf   = rsp_ovf_r;

endmodule

// File: tb/tb_add_sched.sv
// -----------------------------------------------------------------------------
// tb_add_sched -- directed bench for add_sched with NREQ=4 and
// SETTLE_CYCLES=2. The expected values are hand-computed. The subtract
// expectations follow ADD_SCHED_SUB_EN.
// -----------------------------------------------------------------------------
module tb_add_sched;

  localparam int NREQ   = 4;
  localparam int SETTLE = 2;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*32-1:0]  req_a;
  logic [NREQ*32-1:0]  req_b;
  logic [NREQ-1:0]     req_sub;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [1:0]          rsp_id;
  logic [31:0]         rsp_sum;
  logic                rsp_cout;
  logic                rsp_ovf;

  int n_checks;
  int n_pass;

  add_sched #(.NREQ(NREQ), .SETTLE_CYCLES(SETTLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Move to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One complete transaction on a single requester, with rsp_ready held low
  // until the result has been checked.
  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic [31:0] es, input logic ec,
                       input logic eo, input string tag);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    req_valid           = oh;
    req_a[id*32 +: 32]  = a;
    req_b[id*32 +: 32]  = b;
    req_sub[id]         = sub;
    rsp_ready           = 1'b0;
    #1;
    check({tag, "_grant"}, 64'(req_ready), 64'(oh));
    tick();                                   // T+1
    req_valid = 4'b0000;
    req_a     = {4{32'hDEAD_BEEF}};           // latched operands must be used
    req_b     = {4{32'h1234_5678}};
    req_sub   = 4'b0000;
    #1;
    check({tag, "_v_t1"}, 64'(rsp_valid), 64'd0);
    tick();                                   // T+2
    check({tag, "_v_t2"}, 64'(rsp_valid), 64'd0);
    tick();                                   // T+3
    check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, "_id"},    64'(rsp_id),    64'(id));
    check({tag, "_sum"},   64'(rsp_sum),   64'(es));
    check({tag, "_cout"},  64'(rsp_cout),  64'(ec));
    check({tag, "_ovf"},   64'(rsp_ovf),   64'(eo));
    rsp_ready = 1'b1;
    tick();
    check({tag, "_drop"}, 64'(rsp_valid), 64'd0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int         ngr;
    int         gidx [5];
    int         gcyc [5];
    logic       seen;

    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    req_sub   = 4'b0000;
    rsp_ready = 1'b0;
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_sum",   64'(rsp_sum),   64'd0);
    check("rst_cout",  64'(rsp_cout),  64'd0);
    check("rst_ovf",   64'(rsp_ovf),   64'd0);
    check("rst_id",    64'(rsp_id),    64'd0);
    req_valid = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Basic adds with carry and overflow cases.
    do_op(1, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, "add");
    do_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "carry");
    do_op(2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "ovf_pos");
    do_op(3, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, "ovf_neg");
`ifdef ADD_SCHED_SUB_EN
    do_op(3, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_neg");
    do_op(1, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
`else
    do_op(3, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'h0000_000C, 1'b0, 1'b0, "sub_off");
    do_op(1, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h8000_0001, 1'b0, 1'b0, "sub_off_ovf");
`endif

    // Round robin: all requesters valid, consumer always ready.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*32 +: 32] = 32'(i + 1);
      req_b[i*32 +: 32] = 32'd100;
    end
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    ngr = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      #1;
      if ((req_ready != 4'b0000) && (ngr < 5)) begin
        for (int j = 0; j < NREQ; j++) begin
          if (req_ready[j]) gidx[ngr] = j;
        end
        gcyc[ngr] = cyc;
        ngr++;
      end
      tick();
    end
    req_valid = 4'b0000;
    check("rr_count", 64'(ngr), 64'd5);
    for (int k = 0; k < ngr; k++) begin
      check($sformatf("rr_order%0d", k), 64'(gidx[k]), 64'(k % NREQ));
      if (k > 0) begin
        check($sformatf("rr_gap%0d", k), 64'(gcyc[k] - gcyc[k-1]), 64'd4);
      end
    end
    repeat (6) tick();
    rsp_ready = 1'b0;

    // Backpressure: the result is held while other requesters wait.
    req_a[2*32 +: 32] = 32'd10;
    req_b[2*32 +: 32] = 32'd20;
    req_valid = 4'b0100;
    #1;
    check("bp_grant", 64'(req_ready), 64'h4);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    req_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      #1;
      check($sformatf("bp_valid%0d", c), 64'(rsp_valid), 64'd1);
      check($sformatf("bp_sum%0d", c),   64'(rsp_sum),   64'd30);
      check($sformatf("bp_id%0d", c),    64'(rsp_id),    64'd2);
      check($sformatf("bp_ready%0d", c), 64'(req_ready), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_hold", 64'(rsp_valid), 64'd1);
    tick();
    rsp_ready = 1'b0;
    check("bp_release", 64'(rsp_valid), 64'd0);
    check("bp_next_grant", 64'(req_ready), 64'h8);
    req_valid = 4'b0000;
    #1;
    tick();

    // Reset one cycle after a grant aborts the operation.
    req_valid = 4'b0100;
    #1;
    check("rs_grant", 64'(req_ready), 64'h4);
    tick();
    req_valid = 4'b0000;
    rst = 1'b1;
    #1;
    check("rs_valid_now", 64'(rsp_valid), 64'd0);
    tick();
    rst  = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    check("rs_no_valid", 64'(seen), 64'd0);
    req_valid = 4'hF;
    #1;
    check("rs_first_grant", 64'(req_ready), 64'h1);
    req_valid = 4'b0000;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
